// File: rtl/control_area_sequencer_if.sv
// Word-read memory port between the sequencer (master) and program memory (slave).
interface control_area_sequencer_if;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 32;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/control_area_sequencer.sv
// Fetches and executes ICA (per-field) and DCA (per-line) control programs,
// producing register writes, video start address reloads and interrupts.
module control_area_sequencer #(
  localparam int unsigned AW    = 20,
  localparam int unsigned DW    = 32,
  localparam int unsigned OPW   = 8,
  localparam int unsigned RAW   = 7,
  localparam int unsigned RDW   = 24,
  localparam int unsigned CNTW  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     new_frame,
  input  logic                     new_line,
  input  logic                     display_active,
  input  logic                     dca_enable,
  input  logic [AW-1:0]            ica_base,
  control_area_sequencer_if.master mem,
  output logic                     reg_we,
  output logic [RAW-1:0]           reg_addr,
  output logic [RDW-1:0]           reg_data,
  output logic                     vsr_load,
  output logic [AW-1:0]            vsr_data,
  output logic                     irq,
  output logic                     overrun,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] LAST_DCA_INSTR = CNTW'(15);
  localparam logic [AW-1:0]   DCA_STRIDE     = AW'(16);

  state_t          state_q, state_d;
  logic            mode_dca_q, mode_dca_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [AW-1:0]   arg_q, arg_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   dcp_q, dcp_d;
  logic [AW-1:0]   line_base_q, line_base_d;
  logic [AW-1:0]   reload_val_q, reload_val_d;
  logic            reload_pend_q, reload_pend_d;
  logic            pend_ica_q, pend_ica_d;
  logic            pend_dca_q, pend_dca_d;
  logic [CNTW-1:0] exec_cnt_q, exec_cnt_d;
  logic            mem_req_q, mem_req_d;

  logic            reg_we_d, vsr_load_d, irq_d, overrun_d, busy_d;
  logic [RAW-1:0]  reg_addr_d;
  logic [RDW-1:0]  reg_data_d;
  logic [AW-1:0]   vsr_data_d;

  logic            start, abort, finish;
  logic [OPW-1:0]  fetched_op;

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = ptr_q;
  assign fetched_op   = mem.mem_data[DW-1 -: OPW];

  // Next-state, datapath and output decode
  always_comb begin
    state_d       = state_q;
    mode_dca_d    = mode_dca_q;
    op_d          = op_q;
    arg_d         = arg_q;
    ptr_d         = ptr_q;
    dcp_d         = dcp_q;
    line_base_d   = line_base_q;
    reload_val_d  = reload_val_q;
    reload_pend_d = reload_pend_q;
    exec_cnt_d    = exec_cnt_q;
    reg_we_d      = 1'b0;
    reg_addr_d    = reg_addr;
    reg_data_d    = reg_data;
    vsr_load_d    = 1'b0;
    vsr_data_d    = vsr_data;
    irq_d         = 1'b0;
    overrun_d     = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    finish        = 1'b0;

    // A frame start outranks and cancels any line start
    pend_ica_d = pend_ica_q | new_frame;
    pend_dca_d = (pend_dca_q | (new_line & display_active & dca_enable)) & ~new_frame;

    case (state_q)
      IDLE: begin
        start = pend_ica_d | pend_dca_d;
      end
      FETCH: begin
        if (mem.mem_ack) begin
          if (pend_ica_d | pend_dca_d) begin
            start = 1'b1;
            abort = 1'b1;
          end else begin
            state_d    = EXEC;
            op_d       = fetched_op;
            arg_d      = mem.mem_data[AW-1:0];
            ptr_d      = ptr_q + AW'(1);
            reg_we_d   = fetched_op[OPW-1];
            vsr_load_d = (fetched_op[OPW-1 -: 4] == 4'h4);
            irq_d      = (fetched_op[OPW-1 -: 4] == 4'h6);
            if (fetched_op[OPW-1]) begin
              reg_addr_d = fetched_op[RAW-1:0];
              reg_data_d = mem.mem_data[RDW-1:0];
            end
            if (fetched_op[OPW-1 -: 4] == 4'h4) begin
              vsr_data_d = mem.mem_data[AW-1:0];
            end
          end
        end
      end
      EXEC: begin
        // ICA reloads land in dcp at once; DCA reloads wait for program end
        if (op_q[OPW-1 -: 3] == 3'b001) begin
          if (mode_dca_q) begin
            reload_pend_d = 1'b1;
            reload_val_d  = arg_q;
          end else begin
            dcp_d = arg_q;
          end
        end
        exec_cnt_d = exec_cnt_q + CNTW'(1);
        finish     = (op_q[OPW-1 -: 4] == 4'h0) || (op_q[OPW-1 -: 4] == 4'h3) ||
                     (mode_dca_q && (exec_cnt_q == LAST_DCA_INSTR));
        state_d    = finish ? IDLE : FETCH;
        if (pend_ica_d | pend_dca_d) begin
          start = 1'b1;
          abort = ~finish;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (mode_dca_q && (finish || abort)) begin
      dcp_d         = reload_pend_d ? reload_val_d : line_base_q + DCA_STRIDE;
      reload_pend_d = 1'b0;
    end

    if (start) begin
      state_d   = FETCH;
      overrun_d = abort;
      if (pend_ica_d) begin
        mode_dca_d = 1'b0;
        ptr_d      = ica_base;
        pend_ica_d = 1'b0;
      end else begin
        mode_dca_d  = 1'b1;
        ptr_d       = dcp_d;
        line_base_d = dcp_d;
        exec_cnt_d  = '0;
        pend_dca_d  = 1'b0;
      end
    end

    mem_req_d = (state_d == FETCH);
    busy_d    = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      mode_dca_q    <= 1'b0;
      op_q          <= '0;
      arg_q         <= '0;
      ptr_q         <= '0;
      dcp_q         <= '0;
      line_base_q   <= '0;
      reload_val_q  <= '0;
      reload_pend_q <= 1'b0;
      pend_ica_q    <= 1'b0;
      pend_dca_q    <= 1'b0;
      exec_cnt_q    <= '0;
      mem_req_q     <= 1'b0;
      reg_we        <= 1'b0;
      reg_addr      <= '0;
      reg_data      <= '0;
      vsr_load      <= 1'b0;
      vsr_data      <= '0;
      irq           <= 1'b0;
      overrun       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_dca_q    <= mode_dca_d;
      op_q          <= op_d;
      arg_q         <= arg_d;
      ptr_q         <= ptr_d;
      dcp_q         <= dcp_d;
      line_base_q   <= line_base_d;
      reload_val_q  <= reload_val_d;
      reload_pend_q <= reload_pend_d;
      pend_ica_q    <= pend_ica_d;
      pend_dca_q    <= pend_dca_d;
      exec_cnt_q    <= exec_cnt_d;
      mem_req_q     <= mem_req_d;
      reg_we        <= reg_we_d;
      reg_addr      <= reg_addr_d;
      reg_data      <= reg_data_d;
      vsr_load      <= vsr_load_d;
      vsr_data      <= vsr_data_d;
      irq           <= irq_d;
      overrun       <= overrun_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_control_area_sequencer.sv
// Bench for control_area_sequencer: directed program scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
`timescale 1ns/1ps
module tb_control_area_sequencer;

  localparam int unsigned MOD = 32'h0010_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_frame = 1'b0;
  logic        new_line = 1'b0;
  logic        display_active = 1'b0;
  logic        dca_enable = 1'b0;
  logic [19:0] ica_base = '0;
  logic        reg_we;
  logic [6:0]  reg_addr;
  logic [23:0] reg_data;
  logic        vsr_load;
  logic [19:0] vsr_data;
  logic        irq;
  logic        overrun;
  logic        busy;

  control_area_sequencer_if bus ();

  control_area_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .new_frame      (new_frame),
    .new_line       (new_line),
    .display_active (display_active),
    .dca_enable     (dca_enable),
    .ica_base       (ica_base),
    .mem            (bus),
    .reg_we         (reg_we),
    .reg_addr       (reg_addr),
    .reg_data       (reg_data),
    .vsr_load       (vsr_load),
    .vsr_data       (vsr_data),
    .irq            (irq),
    .overrun        (overrun),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Program memory and responder
  logic [31:0] mem_arr [0:4095];
  logic [19:0] fetch_log [$];
  int          lat_fixed = 1;
  int          cur_lat   = 1;
  int          wait_cnt  = 0;
  bit          rand_lat  = 1'b0;
  bit          spurious  = 1'b0;

  initial begin
    bus.mem_ack  = 1'b0;
    bus.mem_data = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req === 1'b1) begin
        if (wait_cnt >= cur_lat) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = mem_arr[bus.mem_addr[11:0]];
          fetch_log.push_back(bus.mem_addr);
          wait_cnt = 0;
          cur_lat  = rand_lat ? int'($urandom_range(0, 3)) : lat_fixed;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (spurious && $urandom_range(0, 7) == 0) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = $urandom;
        end
      end
    end
  end

  // Behavioural model: program state kept as plain counters and flags
  bit          m_run, m_fetch, m_dca, m_rlp, m_pica, m_pdca;
  int unsigned m_pc, m_dcp, m_lbase, m_rlv, m_done, m_ins;
  bit          e_req, e_we, e_vsr, e_irq, e_ovr, e_busy;
  int unsigned e_addr, e_ra, e_rd, e_vd;

  function automatic bit op_stop(input int unsigned op);
    return (op <= 32'h0F) || (op >= 32'h30 && op <= 32'h3F);
  endfunction

  function automatic bit op_reload(input int unsigned op);
    return (op >= 32'h20 && op <= 32'h3F);
  endfunction

  task automatic close_dca();
    m_dcp = m_rlp ? m_rlv : (m_lbase + 16) % MOD;
    m_rlp = 1'b0;
  endtask

  task automatic model_step();
    bit          want, launch, aborted, finished;
    int unsigned op, d;
    e_we = 0; e_vsr = 0; e_irq = 0; e_ovr = 0;
    if (reset) begin
      m_run = 0; m_fetch = 0; m_dca = 0; m_rlp = 0; m_pica = 0; m_pdca = 0;
      m_pc = 0; m_dcp = 0; m_lbase = 0; m_rlv = 0; m_done = 0; m_ins = 0;
      e_req = 0; e_busy = 0; e_addr = 0;
      return;
    end
    if (new_frame) begin
      m_pica = 1;
      m_pdca = 0;
    end else if (new_line && display_active && dca_enable) begin
      m_pdca = 1;
    end
    want = m_pica || m_pdca;
    launch = 0;
    aborted = 0;
    finished = 0;
    if (!m_run) begin
      launch = want;
    end else if (m_fetch) begin
      if (bus.mem_ack) begin
        if (want) begin
          launch = 1; aborted = 1;
          if (m_dca) close_dca();
        end else begin
          d = bus.mem_data;
          op = d >> 24;
          m_ins = d;
          m_pc = (m_pc + 1) % MOD;
          m_fetch = 0;
          if (op >= 128) begin e_we = 1; e_ra = op - 128; e_rd = d & 32'h00FF_FFFF; end
          if (op >= 32'h40 && op <= 32'h4F) begin e_vsr = 1; e_vd = d % MOD; end
          if (op >= 32'h60 && op <= 32'h6F) e_irq = 1;
        end
      end
    end else begin
      op = m_ins >> 24;
      if (op_reload(op)) begin
        if (m_dca) begin m_rlp = 1; m_rlv = m_ins % MOD; end
        else m_dcp = m_ins % MOD;
      end
      m_done++;
      finished = op_stop(op) || (m_dca && m_done == 16);
      if (want) begin launch = 1; aborted = !finished; end
      if (m_dca && (finished || aborted)) close_dca();
      if (finished) m_run = 0; else m_fetch = 1;
    end
    if (launch) begin
      m_run = 1; m_fetch = 1; e_ovr = aborted;
      if (m_pica) begin
        m_dca = 0; m_pc = ica_base; m_pica = 0;
      end else begin
        m_dca = 1; m_lbase = m_dcp; m_pc = m_dcp; m_done = 0; m_pdca = 0;
      end
    end
    e_req  = m_run && m_fetch;
    e_busy = m_run;
    e_addr = m_pc;
  endtask

  logic [30:0] reg_log [$];
  logic [19:0] ovr_log [$];
  int          irq_cnt = 0;

  // Model step on each edge, then compare and log once outputs settle
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("mem_req", 32'(bus.mem_req), 32'(e_req));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("overrun", 32'(overrun), 32'(e_ovr));
      chk("reg_we", 32'(reg_we), 32'(e_we));
      chk("vsr_load", 32'(vsr_load), 32'(e_vsr));
      chk("irq", 32'(irq), 32'(e_irq));
      if (e_req) chk("mem_addr", 32'(bus.mem_addr), e_addr);
      if (e_we) begin
        chk("reg_addr", 32'(reg_addr), e_ra);
        chk("reg_data", 32'(reg_data), e_rd);
      end
      if (e_vsr) chk("vsr_data", 32'(vsr_data), e_vd);
      if (reg_we === 1'b1) reg_log.push_back({reg_addr, reg_data});
      if (overrun === 1'b1) ovr_log.push_back(bus.mem_addr);
      if (irq === 1'b1) irq_cnt++;
    end
  end

  task automatic clear_logs();
    fetch_log.delete();
    reg_log.delete();
    ovr_log.delete();
    irq_cnt = 0;
  endtask

  task automatic set_lat(input int l);
    lat_fixed = l;
    cur_lat   = l;
  endtask

  task automatic pulse(input bit f, input bit l);
    @(negedge clk);
    new_frame = f;
    new_line  = l;
    @(negedge clk);
    new_frame = 1'b0;
    new_line  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_busy", 32'(busy), 32'h0);
  endtask

  task automatic chk_fetch(input string name, input int i, input logic [19:0] req);
    chk(name, (i < fetch_log.size()) ? 32'(fetch_log[i]) : 32'hDEAD_BEEF, 32'(req));
  endtask

  function automatic logic [31:0] rand_word();
    logic [7:0]  op;
    int unsigned k = $urandom_range(0, 15);
    case (k)
      0:       op = 8'($urandom_range(8'h00, 8'h0F));
      1:       op = 8'($urandom_range(8'h30, 8'h3F));
      2, 3:    op = 8'($urandom_range(8'h20, 8'h2F));
      4, 5:    op = 8'($urandom_range(8'h40, 8'h4F));
      6:       op = 8'($urandom_range(8'h60, 8'h6F));
      7:       op = 8'($urandom_range(8'h10, 8'h1F));
      8:       op = ($urandom_range(0, 1) == 0) ? 8'h50 : 8'h7A;
      default: op = 8'($urandom_range(8'h80, 8'hFF));
    endcase
    return {op, 24'($urandom)};
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) mem_arr[i] = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // ICA: register write, immediate dcp reload, stop
    ica_base = 20'h00100;
    mem_arr[12'h100] = 32'h8112_3456;
    mem_arr[12'h101] = 32'h2000_0400;
    mem_arr[12'h102] = 32'h0000_0000;
    clear_logs();
    pulse(1'b1, 1'b0);
    wait_idle(100);
    chk("ica_fetch_count", 32'(fetch_log.size()), 32'd3);
    chk_fetch("ica_fetch0", 0, 20'h00100);
    chk_fetch("ica_fetch2", 2, 20'h00102);
    chk("ica_reg_count", 32'(reg_log.size()), 32'd1);
    chk("ica_reg_write", (reg_log.size() > 0) ? 32'(reg_log[0]) : 32'hDEAD_BEEF,
        32'({7'h01, 24'h123456}));

    // DCA of 16 NOPs stops on the instruction limit
    display_active = 1'b1;
    dca_enable     = 1'b1;
    for (int i = 0; i < 16; i++) mem_arr[12'h400 + 12'(i)] = 32'h1000_0000;
    mem_arr[12'h410] = 32'h3000_0800;
    mem_arr[12'h800] = 32'h0000_0000;
    clear_logs();
    pulse(1'b0, 1'b1);
    wait_idle(200);
    chk("dca16_fetch_count", 32'(fetch_log.size()), 32'd16);
    for (int i = 0; i < 16; i++) chk_fetch("dca16_addr", i, 20'h00400 + 20'(i));

    // Reload-and-stop redirects the next line
    clear_logs();
    pulse(1'b0, 1'b1);
    wait_idle(100);
    chk("reload_fetch_count", 32'(fetch_log.size()), 32'd1);
    chk_fetch("reload_addr", 0, 20'h00410);
    clear_logs();
    pulse(1'b0, 1'b1);
    wait_idle(100);
    chk_fetch("after_reload_addr", 0, 20'h00800);

    // Line start during a slow ICA fetch aborts it
    mem_arr[12'h100] = 32'h6000_0000;
    mem_arr[12'h810] = 32'h0000_0000;
    set_lat(5);
    clear_logs();
    pulse(1'b1, 1'b0);
    @(negedge clk);
    pulse(1'b0, 1'b1);
    wait_idle(200);
    chk("abort_fetch_count", 32'(fetch_log.size()), 32'd2);
    chk_fetch("abort_dca_addr", 1, 20'h00810);
    chk("abort_irq_count", 32'(irq_cnt), 32'd0);
    chk("abort_overrun_count", 32'(ovr_log.size()), 32'd1);
    chk("abort_overrun_addr", (ovr_log.size() > 0) ? 32'(ovr_log[0]) : 32'hDEAD_BEEF,
        32'h00810);

    // Simultaneous frame and line: ICA only
    set_lat(1);
    mem_arr[12'h100] = 32'h0000_0000;
    clear_logs();
    pulse(1'b1, 1'b1);
    wait_idle(100);
    repeat (5) @(negedge clk);
    chk("simul_fetch_count", 32'(fetch_log.size()), 32'd1);
    chk_fetch("simul_addr", 0, 20'h00100);
    chk("simul_overrun", 32'(ovr_log.size()), 32'd0);

    // Reset mid-fetch; a frame start seen under reset is ignored
    mem_arr[12'h100] = 32'h1000_0000;
    set_lat(5);
    clear_logs();
    pulse(1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mem_req", 32'(bus.mem_req), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    new_frame = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    new_frame = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", 32'(busy), 32'h0);
    set_lat(1);
    clear_logs();
    pulse(1'b0, 1'b1);
    wait_idle(100);
    chk_fetch("post_reset_dcp", 0, 20'h00000);
    clear_logs();
    pulse(1'b1, 1'b0);
    wait_idle(100);
    chk_fetch("post_reset_ica", 0, 20'h00100);

    // Randomized traffic against the model
    for (int i = 0; i < 4096; i++) mem_arr[i] = rand_word();
    rand_lat = 1'b1;
    spurious = 1'b1;
    repeat (20000) begin
      @(negedge clk);
      new_frame = ($urandom_range(0, 299) == 0);
      new_line  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) display_active = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) dca_enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0)
        ica_base = ($urandom_range(0, 3) == 0) ? 20'hFFFF8 + 20'($urandom_range(0, 7))
                                               : 20'($urandom);
      reset = ($urandom_range(0, 2999) == 0);
      mem_arr[$urandom_range(0, 4095)] = rand_word();
    end
    @(negedge clk);
    new_frame = 1'b0;
    new_line  = 1'b0;
    reset     = 1'b0;
    repeat (200) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
